rf_wb_arbiter: RTL and testbench

- Sole owner of the register-file write port (addr_rd / data_rd / write_enable).
- Shares that port between two writeback requesters: ch0 (ALU result) and ch1 (load data).
- Keeps a per-register pending-write scoreboard that the issue stage queries for RAW stalls.
- Sits between execute/memory writeback and the register file; the issue stage drives reservations and queries.

---
 rtl/rf_wb_arbiter_if.sv | 60 ++++++
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bundle: reservations, two writeback requesters, register-file write port, RAW queries.
// Latency: none, wires only.
// Backpressure: each channel is valid/ready; the arbiter drives ready.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Issue-stage reservation of a destination register
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;

    // ch0: ALU writeback
    logic              ch0_valid;
    logic [ADDR_W-1:0] ch0_addr;
    logic [DATA_W-1:0] ch0_data;
    logic              ch0_ready;

    // ch1: load writeback
    logic              ch1_valid;
    logic [ADDR_W-1:0] ch1_addr;
    logic [DATA_W-1:0] ch1_data;
    logic              ch1_ready;

    // Register-file write port
    logic [ADDR_W-1:0] rf_addr_rd;
    logic [DATA_W-1:0] rf_data_rd;
    logic              rf_write_enable;

    // Hazard queries and status
    logic [ADDR_W-1:0] query_rs1;
    logic [ADDR_W-1:0] query_rs2;
    logic              busy_rs1;
    logic              busy_rs2;
    logic              err_unreserved;
    logic              idle;

    // Arbiter side
    modport slave (
        input  rsv_valid, rsv_addr,
        input  ch0_valid, ch0_addr, ch0_data,
        output ch0_ready,
        input  ch1_valid, ch1_addr, ch1_data,
        output ch1_ready,
        output rf_addr_rd, rf_data_rd, rf_write_enable,
        input  query_rs1, query_rs2,
        output busy_rs1, busy_rs2, err_unreserved, idle
    );

    // Pipeline / issue side
    modport master (
        output rsv_valid, rsv_addr,
        output ch0_valid, ch0_addr, ch0_data,
        input  ch0_ready,
        output ch1_valid, ch1_addr, ch1_data,
        input  ch1_ready,
        input  rf_addr_rd, rf_data_rd, rf_write_enable,
        output query_rs1, query_rs2,
        input  busy_rs1, busy_rs2, err_unreserved, idle
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin owner of the register-file write port, plus a pending-write scoreboard for RAW stalls.
// Latency: a request accepted at edge N is written by the register file at edge N+1; one write per cycle.
// Backpressure: ready is combinational; the losing channel holds valid until it is granted.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);
    localparam int NUM_REGS = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    logic                rr_last;      // index of the most recently granted channel
    logic                gnt0;
    logic                gnt1;
    wb_req_t             sel_req;
    wb_req_t             out_req;
    logic                out_we;
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic                err_q;
    logic                err_d;
    logic                rsv_set;

    // Grant: a lone requester wins; under contention the channel not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.ch0_valid && (!bus.ch1_valid || rr_last)) begin
                gnt0 = 1'b1;
            end else if (bus.ch1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Mux the granted channel into the request struct
    always_comb begin
        sel_req = '{addr: bus.ch0_addr, data: bus.ch0_data};
        if (gnt1) begin
            sel_req = '{addr: bus.ch1_addr, data: bus.ch1_data};
        end
    end

    assign bus.ch0_ready = gnt0;
    assign bus.ch1_ready = gnt1;

    // Round-robin pointer; reset to 1 so ch0 wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (gnt0) begin
            rr_last <= 1'b0;
        end else if (gnt1) begin
            rr_last <= 1'b1;
        end
    end

    // Output register: address/data hold when idle, x0 writes are swallowed by dropping the enable
    always_ff @(posedge clk) begin
        if (rst) begin
            out_req <= '0;
            out_we  <= 1'b0;
        end else if (gnt0 || gnt1) begin
            out_req <= sel_req;
            out_we  <= (sel_req.addr != '0);
        end else begin
            out_we  <= 1'b0;
        end
    end

    assign bus.rf_addr_rd      = out_req.addr;
    assign bus.rf_data_rd      = out_req.data;
    assign bus.rf_write_enable = out_we;

    assign rsv_set = bus.rsv_valid && (bus.rsv_addr != '0);

    // Scoreboard next state: clear on commit, then a same-cycle reservation re-sets the bit
    always_comb begin
        sb_d = sb_q;
        if (out_we) begin
            sb_d[out_req.addr] = 1'b0;
        end
        if (rsv_set) begin
            sb_d[bus.rsv_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Sticky flag for a commit to a register nobody reserved
    always_comb begin
        err_d = err_q;
        if (out_we && (out_req.addr != '0) && !sb_q[out_req.addr] &&
            !(rsv_set && (bus.rsv_addr == out_req.addr))) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard and error flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sb_q  <= sb_d;
            err_q <= err_d;
        end
    end

    assign bus.busy_rs1       = sb_q[bus.query_rs1];
    assign bus.busy_rs2       = sb_q[bus.query_rs2];
    assign bus.err_unreserved = err_q;
    assign bus.idle           = (sb_q == '0) && !out_we;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, contention, x0, set/clear collision, unreserved write.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Expected values are written out by hand for each step.
module tb_rf_wb_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [4:0]  q0_addr [3];
    logic [31:0] q0_data [3];
    logic [4:0]  q1_addr [3];
    logic [31:0] q1_data [3];
    logic [4:0]  rsv_list [6];
    int          i0;
    int          i1;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.rsv_valid = 1'b0; bus.rsv_addr = '0;
        bus.ch0_valid = 1'b0; bus.ch0_addr = '0; bus.ch0_data = '0;
        bus.ch1_valid = 1'b0; bus.ch1_addr = '0; bus.ch1_data = '0;
        bus.query_rs1 = '0;   bus.query_rs2 = '0;

        // ---- reset state
        step();
        step();
        chk1 ("rst_we",   bus.rf_write_enable, 1'b0);
        chk32("rst_addr", 32'(bus.rf_addr_rd), 32'd0);
        chk32("rst_data", bus.rf_data_rd, 32'd0);
        chk1 ("rst_err",  bus.err_unreserved, 1'b0);
        chk1 ("rst_idle", bus.idle, 1'b1);

        // ---- reset mid-stream with reservation and request pending
        rst = 1'b0;
        step();
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd5;
        step();
        bus.rsv_valid = 1'b0;
        bus.query_rs1 = 5'd5;
        #1;
        chk1("x5_busy_before_rst", bus.busy_rs1, 1'b1);
        bus.ch0_valid = 1'b1; bus.ch0_addr = 5'd5; bus.ch0_data = 32'h5555_5555;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd6;
        rst = 1'b1;
        #1;
        chk1("ch0_ready_in_rst", bus.ch0_ready, 1'b0);
        step();
        bus.ch0_valid = 1'b0; bus.rsv_valid = 1'b0;
        rst = 1'b0;
        chk1("midrst_we",   bus.rf_write_enable, 1'b0);
        chk1("midrst_busy", bus.busy_rs1, 1'b0);
        chk1("midrst_err",  bus.err_unreserved, 1'b0);
        chk1("midrst_idle", bus.idle, 1'b1);

        // ---- single channel write of x7
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
        step();
        bus.rsv_valid = 1'b0;
        bus.query_rs1 = 5'd7;
        bus.ch0_valid = 1'b1; bus.ch0_addr = 5'd7; bus.ch0_data = 32'hDEAD_BEEF;
        #1;
        chk1("single_ch0_ready", bus.ch0_ready, 1'b1);
        chk1("single_busy_pre",  bus.busy_rs1, 1'b1);
        step();
        bus.ch0_valid = 1'b0;
        chk1 ("single_we",   bus.rf_write_enable, 1'b1);
        chk32("single_addr", 32'(bus.rf_addr_rd), 32'd7);
        chk32("single_data", bus.rf_data_rd, 32'hDEAD_BEEF);
        chk1 ("single_busy_commit", bus.busy_rs1, 1'b1);
        chk1 ("single_idle_commit", bus.idle, 1'b0);
        step();
        chk1("single_busy_after", bus.busy_rs1, 1'b0);
        chk1("single_idle_after", bus.idle, 1'b1);
        chk1("single_we_after",   bus.rf_write_enable, 1'b0);
        chk1("single_err",        bus.err_unreserved, 1'b0);

        // ---- contention: both channels held valid, grants alternate from ch0
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsv_list = '{5'd3, 5'd4, 5'd13, 5'd14, 5'd15, 5'd16};
        q0_addr = '{5'd3, 5'd13, 5'd15};
        q0_data = '{32'h11, 32'h33, 32'h55};
        q1_addr = '{5'd4, 5'd14, 5'd16};
        q1_data = '{32'h22, 32'h44, 32'h66};
        for (int k = 0; k < 6; k++) begin
            bus.rsv_valid = 1'b1; bus.rsv_addr = rsv_list[k];
            step();
        end
        bus.rsv_valid = 1'b0;
        i0 = 0;
        i1 = 0;
        bus.ch0_valid = 1'b1; bus.ch0_addr = q0_addr[0]; bus.ch0_data = q0_data[0];
        bus.ch1_valid = 1'b1; bus.ch1_addr = q1_addr[0]; bus.ch1_data = q1_data[0];
        for (int k = 0; k < 6; k++) begin
            #1;
            chk1("cont_ch0_ready", bus.ch0_ready, (k % 2) == 0);
            chk1("cont_ch1_ready", bus.ch1_ready, (k % 2) == 1);
            step();
            chk1("cont_we", bus.rf_write_enable, 1'b1);
            if ((k % 2) == 0) begin
                chk32("cont_addr", 32'(bus.rf_addr_rd), 32'(q0_addr[i0]));
                chk32("cont_data", bus.rf_data_rd, q0_data[i0]);
                i0++;
                if (i0 < 3) begin
                    bus.ch0_addr = q0_addr[i0]; bus.ch0_data = q0_data[i0];
                end else begin
                    bus.ch0_valid = 1'b0;
                end
            end else begin
                chk32("cont_addr", 32'(bus.rf_addr_rd), 32'(q1_addr[i1]));
                chk32("cont_data", bus.rf_data_rd, q1_data[i1]);
                i1++;
                if (i1 < 3) begin
                    bus.ch1_addr = q1_addr[i1]; bus.ch1_data = q1_data[i1];
                end else begin
                    bus.ch1_valid = 1'b0;
                end
            end
        end
        step();
        chk1("cont_idle", bus.idle, 1'b1);
        chk1("cont_err",  bus.err_unreserved, 1'b0);

        // ---- write to x0 is accepted but never reaches the register file
        bus.ch1_valid = 1'b1; bus.ch1_addr = 5'd0; bus.ch1_data = 32'hFFFF_FFFF;
        #1;
        chk1("x0_ch1_ready", bus.ch1_ready, 1'b1);
        step();
        bus.ch1_valid = 1'b0;
        chk1 ("x0_we",   bus.rf_write_enable, 1'b0);
        chk32("x0_data", bus.rf_data_rd, 32'hFFFF_FFFF);
        step();
        chk1("x0_err",  bus.err_unreserved, 1'b0);
        chk1("x0_idle", bus.idle, 1'b1);

        // ---- set/clear collision on x9
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
        step();
        bus.rsv_valid = 1'b0;
        bus.ch0_valid = 1'b1; bus.ch0_addr = 5'd9; bus.ch0_data = 32'h99;
        step();
        bus.ch0_valid = 1'b0;
        chk1("coll_we", bus.rf_write_enable, 1'b1);
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
        step();
        bus.rsv_valid = 1'b0;
        bus.query_rs2 = 5'd9;
        #1;
        chk1("coll_busy", bus.busy_rs2, 1'b1);
        chk1("coll_err",  bus.err_unreserved, 1'b0);
        bus.ch0_valid = 1'b1; bus.ch0_addr = 5'd9; bus.ch0_data = 32'h9A;
        step();
        bus.ch0_valid = 1'b0;
        step();
        chk1("coll_busy_done", bus.busy_rs2, 1'b0);
        chk1("coll_err_done",  bus.err_unreserved, 1'b0);
        chk1("coll_idle",      bus.idle, 1'b1);

        // ---- unreserved write to x12 is performed and flagged
        bus.ch0_valid = 1'b1; bus.ch0_addr = 5'd12; bus.ch0_data = 32'h00C0_FFEE;
        step();
        bus.ch0_valid = 1'b0;
        chk1 ("unres_we",     bus.rf_write_enable, 1'b1);
        chk32("unres_addr",   32'(bus.rf_addr_rd), 32'd12);
        chk1 ("unres_err_pre", bus.err_unreserved, 1'b0);
        step();
        chk1("unres_err", bus.err_unreserved, 1'b1);
        step();
        step();
        chk1("unres_err_sticky", bus.err_unreserved, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("unres_err_cleared", bus.err_unreserved, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
